// File: rtl/fp_pack_pkg.sv
// Shared types and constants for the significand pack datapath.
// Contents: FSM state enum, exponent biases, saturated biased exponents,
// fraction field widths and internal widths.
package fp_pack_pkg;

  typedef enum logic [1:0] {IDLE, NORM, DENORM, DONE} state_e;

  localparam int BIAS_D  = 1023;
  localparam int BIAS_S  = 127;
  localparam int EMAXB_D = 2047;
  localparam int EMAXB_S = 255;
  localparam int FRAC_D  = 52;
  localparam int FRAC_S  = 23;

  localparam int SIGW    = 53;  // significand width, hidden bit at [52]

endpackage

// File: rtl/sig_norm_shift.sv
// Combinational normalizer for the 53-bit significand.
// Ports:
//   f_i    : significand in, may carry leading zeros
//   lz_o   : number of leading zeros (53 when f_i == 0)
//   f_o    : f_i shifted left by lz_o (hidden bit at [52])
//   zero_o : f_i is all zeros
module sig_norm_shift
  import fp_pack_pkg::*;
#(
  parameter int LZW = 6
) (
  input  logic [SIGW-1:0] f_i,
  output logic [LZW-1:0]  lz_o,
  output logic [SIGW-1:0] f_o,
  output logic            zero_o
);

  logic found;

  // Priority scan from the MSB; the first set bit fixes the count.
  always_comb begin
    lz_o  = LZW'(SIGW);
    found = 1'b0;
    for (int i = SIGW - 1; i >= 0; i--) begin
      if (!found && f_i[i]) begin
        lz_o  = LZW'(SIGW - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign zero_o = ~found;
  assign f_o    = f_i << lz_o;

endmodule

// File: rtl/significand_pack.sv
// Packs sign / unbiased exponent / 53-bit significand into an IEEE word.
// Three-step iterative FSM (NORM, DENORM, DONE), one operation in flight,
// valid/ready on both sides. Singles land in y[63:32], y[31:0] = 0.
// No rounding: fraction bits below the field are truncated.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready only in IDLE)
//   db, s, e, f, fz     : precision, sign, exponent, significand, force zero
//   out_valid/out_ready : result handshake, y held while stalled
//   y                   : packed result
// Optional feature macro SIG_PACK_FLAGS_EN adds ovf/unf/inx outputs,
// registered alongside y.
module significand_pack
  import fp_pack_pkg::*;
#(
  parameter int N   = 64,
  parameter int EW  = 13,
  parameter int LZW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            db,
  input  logic            s,
  input  logic [EW-1:0]   e,
  input  logic [SIGW-1:0] f,
  input  logic            fz,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    y
`ifdef SIG_PACK_FLAGS_EN
  ,
  output logic            ovf,
  output logic            unf,
  output logic            inx
`endif
);

  state_e               state_q;
  logic                 in_ready_q, out_valid_q;
  logic [N-1:0]         y_q;
  logic                 db_q, s_q, fz_q, zero_q;
  logic [SIGW-1:0]      f_q;
  logic signed [EW:0]   x_q;

  // Normalizer on the captured significand
  logic [LZW-1:0]       lz;
  logic [SIGW-1:0]      f_nrm;
  logic                 f_zero;

  sig_norm_shift #(.LZW(LZW)) u_norm (
    .f_i    (f_q),
    .lz_o   (lz),
    .f_o    (f_nrm),
    .zero_o (f_zero)
  );

  // DENORM-step datapath, results registered into y_q on the way to DONE
  logic signed [EW:0]   eb_d, emaxb;
  logic [LZW-1:0]       sh_d;
  logic [SIGW-1:0]      f_d;
  logic [10:0]          ebf_d;
  logic [N-1:0]         y_d;
  logic                 ovf_d, unf_d, inx_d;
  logic [63:0]          lost_mask;
  logic                 unused_msb;

  always_comb begin
    eb_d      = x_q + (db_q ? (EW+1)'(BIAS_D) : (EW+1)'(BIAS_S));
    emaxb     = db_q ? (EW+1)'(EMAXB_D) : (EW+1)'(EMAXB_S);
    sh_d      = '0;
    f_d       = f_q;
    ebf_d     = eb_d[10:0];
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    inx_d     = 1'b0;
    lost_mask = '0;
    if (zero_q || fz_q) begin
      f_d   = '0;
      ebf_d = '0;
    end else if (eb_d <= 0) begin
      // Shift by 1-eb so the implicit bit lands in the fraction field;
      // anything past 63 is a full flush anyway.
      sh_d      = (eb_d < -62) ? LZW'(63) : LZW'(1 - eb_d);
      lost_mask = (64'd1 << sh_d) - 64'd1;
      f_d       = f_q >> sh_d;
      ebf_d     = '0;
      unf_d     = 1'b1;
      inx_d     = |({{(64-SIGW){1'b0}}, f_q} & lost_mask);
    end else if (eb_d >= emaxb) begin
      ebf_d = emaxb[10:0];
      f_d   = '0;
      ovf_d = 1'b1;
    end
    // Single keeps f[51:29]; the 29 bits below fall off the field.
    if (!db_q && (f_d[FRAC_D-FRAC_S-1:0] != '0)) inx_d = 1'b1;
    if (db_q) y_d = {s_q, ebf_d, f_d[FRAC_D-1:0]};
    else      y_d = {s_q, ebf_d[7:0], f_d[FRAC_D-1:FRAC_D-FRAC_S], 32'h0};
  end

  assign unused_msb = f_d[SIGW-1];

`ifdef SIG_PACK_FLAGS_EN
  logic ovf_q, unf_q, inx_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      db_q        <= 1'b0;
      s_q         <= 1'b0;
      fz_q        <= 1'b0;
      zero_q      <= 1'b0;
      f_q         <= '0;
      x_q         <= '0;
`ifdef SIG_PACK_FLAGS_EN
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          db_q       <= db;
          s_q        <= s;
          fz_q       <= fz;
          f_q        <= f;
          x_q        <= {e[EW-1], e};
          in_ready_q <= 1'b0;
          state_q    <= NORM;
        end
        NORM: begin
          f_q     <= f_nrm;
          x_q     <= x_q - $signed({{(EW+1-LZW){1'b0}}, lz});
          zero_q  <= f_zero;
          state_q <= DENORM;
        end
        DENORM: begin
          y_q         <= y_d;
          out_valid_q <= 1'b1;
`ifdef SIG_PACK_FLAGS_EN
          ovf_q       <= ovf_d;
          unf_q       <= unf_d;
          inx_q       <= inx_d;
`endif
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;

`ifdef SIG_PACK_FLAGS_EN
  assign ovf = ovf_q;
  assign unf = unf_q;
  assign inx = inx_q;
`else
  logic unused_flags;
  assign unused_flags = ^{ovf_d, unf_d, inx_d, lost_mask};
`endif

endmodule
